// File: rtl/gpu_rect_reader.sv
// gpu_rect_reader: scans a rectangle of the framebuffer through RAM port 2.
// The scan is row-major. Pixels are 1 bit each and are packed PACK_WIDTH to a
// word, with bit0 holding the leftmost pixel. Every row ends its own word, and
// the unused upper bits of a partial word are zero. Words are sent on a
// valid/ready stream.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   X1,Y1,X2,Y2           rectangle corners, sampled on start_read
//   start_read            request pulse, honoured only when idle
//   busy, done            operation in flight / one-cycle completion pulse
//   ram_x, ram_y          RAM port 2 address
//   ram_enable_read       RAM port 2 read strobe
//   ram_read_value        pixel returned one cycle after the strobe
//   out_data, out_valid   packed word stream to the host side
//   out_ready, out_last
//   crc                   CRC-8 over accepted words (optional)
//
// Build option: define GPU_RECT_READER_CRC_EN to enable the CRC-8
// (poly 0x07, init 0x00, MSB-first) over out_data[7:0] of each accepted word.
// When the macro is not defined, crc is tied to zero.
module gpu_rect_reader #(
  parameter int unsigned PACK_WIDTH = 8,
  parameter int unsigned X_W        = 9,
  parameter int unsigned Y_W        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [X_W-1:0]        X1,
  input  logic [Y_W-1:0]        Y1,
  input  logic [X_W-1:0]        X2,
  input  logic [Y_W-1:0]        Y2,
  input  logic                  start_read,
  output logic                  busy,
  output logic                  done,
  output logic [X_W-1:0]        ram_x,
  output logic [Y_W-1:0]        ram_y,
  output logic                  ram_enable_read,
  input  logic                  ram_read_value,
  output logic [PACK_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [7:0]            crc
);

  localparam int unsigned BIT_W = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PACK_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [X_W-1:0]          xl_q, xl_d, xh_q, xh_d, cx_q, cx_d;
  logic [Y_W-1:0]          yh_q, yh_d, cy_q, cy_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [X_W-1:0]          ram_x_q, ram_x_d;
  logic [Y_W-1:0]          ram_y_q, ram_y_d;
  logic                    ram_en_q, ram_en_d;
  logic [PACK_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;

  logic start_acc;
  logic word_acc;

  assign start_acc = (state_q == S_IDLE) && start_read;
  assign word_acc  = (state_q == S_EMIT) && valid_q && out_ready;

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    xl_d     = xl_q;
    xh_d     = xh_q;
    yh_d     = yh_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    bit_d    = bit_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ram_x_d  = ram_x_q;
    ram_y_d  = ram_y_q;
    ram_en_d = 1'b0;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_read) begin
          // Normalise the corners so that the scan always runs low to high.
          xl_d     = (X1 < X2) ? X1 : X2;
          xh_d     = (X1 < X2) ? X2 : X1;
          yh_d     = (Y1 < Y2) ? Y2 : Y1;
          cx_d     = xl_d;
          cy_d     = (Y1 < Y2) ? Y1 : Y2;
          bit_d    = '0;
          data_d   = '0;
          busy_d   = 1'b1;
          ram_x_d  = cx_d;
          ram_y_d  = cy_d;
          ram_en_d = 1'b1;
          state_d  = S_READ;
        end
      end

      S_READ: begin
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        data_d[bit_q] = ram_read_value;
        if ((bit_q == BIT_LAST) || (cx_q == xh_q)) begin
          valid_d = 1'b1;
          last_d  = (cx_q == xh_q) && (cy_q == yh_q);
          state_d = S_EMIT;
        end else begin
          bit_d    = bit_q + BIT_W'(1);
          cx_d     = cx_q + X_W'(1);
          ram_x_d  = cx_d;
          ram_y_d  = cy_q;
          ram_en_d = 1'b1;
          state_d  = S_READ;
        end
      end

      S_EMIT: begin
        // Word and last flag are held until the consumer takes them.
        if (word_acc) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            // End of row is found by equality with xh, so 511 never wraps.
            if (cx_q == xh_q) begin
              cx_d = xl_q;
              cy_d = cy_q + Y_W'(1);
            end else begin
              cx_d = cx_q + X_W'(1);
            end
            data_d   = '0;
            bit_d    = '0;
            ram_x_d  = cx_d;
            ram_y_d  = cy_d;
            ram_en_d = 1'b1;
            state_d  = S_READ;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      xl_q     <= '0;
      xh_q     <= '0;
      yh_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      bit_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ram_x_q  <= '0;
      ram_y_q  <= '0;
      ram_en_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xl_q     <= xl_d;
      xh_q     <= xh_d;
      yh_q     <= yh_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      bit_q    <= bit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ram_x_q  <= ram_x_d;
      ram_y_q  <= ram_y_d;
      ram_en_q <= ram_en_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign ram_x           = ram_x_q;
  assign ram_y           = ram_y_q;
  assign ram_enable_read = ram_en_q;
  assign out_data        = data_q;
  assign out_valid       = valid_q;
  assign out_last        = last_q;

`ifdef GPU_RECT_READER_CRC_EN
  logic [7:0] crc_q, crc_d;

  // One byte of CRC-8, poly 0x07, MSB first
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  // Cleared on start, folded with each accepted word, held after done
  always_comb begin
    crc_d = crc_q;
    if (start_acc) begin
      crc_d = 8'h00;
    end else if (word_acc) begin
      crc_d = crc8_byte(crc_q, 8'(data_q));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;
`else
  assign crc = 8'h00;
`endif

endmodule

// File: doc/gpu_rect_reader.md
Name: gpu_rect_reader

Overview:
- Read-side counterpart to the rectangle-fill write path.
- Takes a rectangle request, scans the framebuffer RAM's second port row-major, and packs 1-bit pixels into PACK_WIDTH-bit words.
- Words leave on a valid/ready stream toward the host/readback logic.
- Sits between the graphics RAM port 2 (read side) and the host interface, in the same clock domain as the ops unit.

Parameters:
- PACK_WIDTH, 8, pixels per output word; legal range 2..32.
- X_W, 9, x coordinate width (0-511).
- Y_W, 8, y coordinate width (0-255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- X1  in  X_W  corner A x
- Y1  in  Y_W  corner A y
- X2  in  X_W  corner B x
- Y2  in  Y_W  corner B y
- start_read  in  1  request pulse; coordinates sampled on the same edge
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final word is accepted
- ram_x  out  X_W  RAM port 2 x address
- ram_y  out  Y_W  RAM port 2 y address
- ram_enable_read  out  1  RAM port 2 read enable
- ram_read_value  in  1  pixel returned one cycle after enable
- out_data  out  PACK_WIDTH  packed pixels; bit0 = leftmost pixel
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_last  out  1  marks final word of the rectangle
- crc  out  8  running CRC (see Optional Feature)

Behaviour:
- Reset (reset low, asynchronous): state IDLE; busy, done, out_valid, out_last, ram_enable_read = 0; ram_x, ram_y, out_data, crc = 0.
- Rectangle normalisation at start: xl = min(X1,X2), xh = max(X1,X2), yl = min(Y1,Y2), yh = max(Y1,Y2); inclusive bounds.
- start_read is accepted only in IDLE. It is ignored while busy, with no queuing.
- Scan order: x from xl to xh, then y from yl to yh.
- End-of-row and end-of-frame are detected by equality with xh/yh, never by counter overflow. Coordinates 511 and 255 are legal.
- States:
  - IDLE: on start_read → latch bounds; cx=xl, cy=yl, bit index 0, busy=1 → READ.
  - READ: drive ram_x=cx, ram_y=cy, ram_enable_read=1 for exactly one cycle → CAPTURE.
  - CAPTURE: ram_read_value is written into out_data[bit index]; ram_enable_read=0.
    - If bit index==PACK_WIDTH-1 or cx==xh → EMIT.
    - Otherwise bit index+1, cx+1 → READ.
  - EMIT: out_valid=1; out_data and out_last held stable until the handshake.
    - out_last=1 iff cx==xh && cy==yh.
    - On out_valid && out_ready:
      - if last → DONE;
      - else if cx==xh → cx=xl, cy+1;
      - else cx+1;
      - then clear out_data, bit index 0 → READ.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Row flush: every row ends a word. A partial word has unused upper bits = 0.
  - Words per row = ceil((xh-xl+1)/PACK_WIDTH).
  - Total words = that × (yh-yl+1).
- Throughput: 2 cycles per pixel, plus ≥1 cycle per word in EMIT. out_ready low stalls in EMIT indefinitely, and no RAM reads are issued while stalled.
- out_valid never drops without a handshake, except on reset.
- Reset mid-operation aborts immediately. No done pulse. The next request starts clean.
- Single pixel (X1==X2, Y1==Y2): exactly one word, bit0=pixel, out_last=1.

Optional Feature:
- Macro: GPU_RECT_READER_CRC_EN.
- Defined:
  - crc is a CRC-8 (poly 0x07, init 0x00, MSB-first) over each accepted out_data word, zero-extended/truncated to 8 bits (bits [7:0]).
  - Cleared to 0 on start accept.
  - Stable and final when done pulses; holds until the next start.
- Undefined: crc tied to 0 and no CRC logic is synthesised.

Test Plan:
- Single-pixel rectangle, RAM model pixel (10,20)=1, request X1=X2=10, Y1=Y2=20, out_ready=1 → one word 0x01, out_last=1. done pulses one cycle after the handshake. Exactly one ram_enable_read is issued, at (10,20).
- Swapped corners X1=17,Y1=3,X2=0,Y2=2, RAM all-ones → 3 words per row × 2 rows = 6 words: 0xFF,0xFF,0x03,0xFF,0xFF,0x03. out_last is set only on the 6th word.
- Edge coordinates X1=504,X2=511,Y1=Y2=255, checkerboard (pixel=x&1) → one word 0xAA, out_last=1. No address wrap occurs: ram_x never exceeds 511.
- Backpressure: 2×1 rectangle with out_ready held low 10 cycles → out_valid stays high and out_data stays constant. No ram_enable_read occurs during the stall. Completion follows when out_ready rises.
- start_read pulsed while busy with different coordinates → ignored; the original word sequence is unchanged.
- Reset asserted mid-scan → all outputs 0 immediately with no done pulse. A following 1×1 request completes normally.
- With GPU_RECT_READER_CRC_EN: single word 0x01 → crc=0x07 at done. Without the macro, crc is always 0.
